// File: rtl/sram_test_reporter.sv
// SRAM tester result reporter: counts passes, captures the first failure and
// streams one fixed-format frame per event over a valid/ready byte interface.
module sram_test_reporter #(
  parameter int DATA_BITS = 16,
  parameter int ITER_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 test_done,
  input  logic                 test_pass,
  input  logic [2:0]           pattern_state,
  input  logic [DATA_BITS-1:0] prev_read_data,
  input  logic [DATA_BITS-1:0] prev_expected_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ITER_BITS-1:0] iter_count,
  output logic                 failed,
  output logic                 busy
);
  // Header, flags, iteration count, read word, expected word.
  localparam int FRAME_LEN = 2 + ITER_BITS/8 + 2*(DATA_BITS/8);
  localparam int FB        = FRAME_LEN*8;
  localparam int CW        = $clog2(FRAME_LEN+1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HALT = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [FB-1:0]        sh_q, sh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ffail_q, ffail_d;
  logic                 pnd_q, pnd_d;
  logic                 pnd_fail_q, pnd_fail_d;
  logic [FB-1:0]        pnd_frame_q, pnd_frame_d;
  logic                 armed_q, failed_q;
  logic [ITER_BITS-1:0] iter_q;

  logic                 fail_evt, pass_evt, evt;
  logic [ITER_BITS-1:0] iter_inc, evt_iter;
  logic [FB-1:0]        evt_frame;

  // Event detection and the frame an event would send this cycle.
  always_comb begin
    fail_evt  = armed_q & ~test_pass & ~failed_q;
    pass_evt  = test_done & ~failed_q & ~fail_evt;
    evt       = fail_evt | pass_evt;
    iter_inc  = (iter_q == '1) ? iter_q : iter_q + 1'b1;
    evt_iter  = pass_evt ? iter_inc : iter_q;
    evt_frame = {8'hA5, fail_evt, 4'b0, pattern_state, evt_iter,
                 prev_read_data, prev_expected_data};
  end

  // Frame sequencer with a one-deep pending slot holding the newest event.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    ffail_d     = ffail_q;
    pnd_d       = pnd_q;
    pnd_fail_d  = pnd_fail_q;
    pnd_frame_d = pnd_frame_q;
    case (state_q)
      IDLE: begin
        if (evt || pnd_q) begin
          state_d = SEND;
          cnt_d   = '0;
          pnd_d   = 1'b0;
          // A live event is newer than anything pending; a pending fail cannot
          // coexist with a live event since failed is already set.
          if (evt) begin
            sh_d    = evt_frame;
            ffail_d = fail_evt;
          end else begin
            sh_d    = pnd_frame_q;
            ffail_d = pnd_fail_q;
          end
        end
      end
      SEND: begin
        if (tx_ready) begin
          sh_d  = sh_q << 8;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(FRAME_LEN-1))
            state_d = ffail_q ? HALT : IDLE;
        end
        if (evt && (fail_evt || !pnd_fail_q)) begin
          pnd_d       = 1'b1;
          pnd_fail_d  = fail_evt;
          pnd_frame_d = evt_frame;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      ffail_q     <= 1'b0;
      pnd_q       <= 1'b0;
      pnd_fail_q  <= 1'b0;
      pnd_frame_q <= '0;
      armed_q     <= 1'b0;
      failed_q    <= 1'b0;
      iter_q      <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      ffail_q     <= ffail_d;
      pnd_q       <= pnd_d;
      pnd_fail_q  <= pnd_fail_d;
      pnd_frame_q <= pnd_frame_d;
      armed_q     <= armed_q | test_pass;
      if (fail_evt) failed_q <= 1'b1;
      if (pass_evt) iter_q   <= iter_inc;
    end
  end

  assign tx_valid   = (state_q == SEND);
  assign tx_data    = sh_q[FB-1 -: 8];
  assign iter_count = iter_q;
  assign failed     = failed_q;
  assign busy       = (state_q != IDLE) | pnd_q;
endmodule

// File: tb/tb_sram_test_reporter.sv
// Bench for sram_test_reporter: directed scenarios with literal frames plus
// randomized traffic compared every cycle against a frame-level model.
module tb_sram_test_reporter;
  localparam int DB = 16;
  localparam int IB = 16;
  localparam int FL = 2 + IB/8 + 2*(DB/8);

  typedef logic [7:0] bq_t[$];

  logic          clk = 0, reset_n = 0, test_done = 0, test_pass = 0, tx_ready = 0;
  logic [2:0]    ps = 0;
  logic [DB-1:0] rd = 0, ex = 0;
  logic [7:0]    tx_data;
  logic          tx_valid, failed, busy;
  logic [IB-1:0] iter_count;

  sram_test_reporter #(.DATA_BITS(DB), .ITER_BITS(IB)) dut (
    .clk(clk), .reset_n(reset_n), .test_done(test_done), .test_pass(test_pass),
    .pattern_state(ps), .prev_read_data(rd), .prev_expected_data(ex),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .iter_count(iter_count), .failed(failed), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bq_t mk(bit f, logic [2:0] p, logic [IB-1:0] it,
                             logic [DB-1:0] r, logic [DB-1:0] e);
    bq_t q;
    q.push_back(8'hA5);
    q.push_back({f, 4'b0, p});
    for (int i = IB/8-1; i >= 0; i--) q.push_back(it[i*8 +: 8]);
    for (int i = DB/8-1; i >= 0; i--) q.push_back(r[i*8 +: 8]);
    for (int i = DB/8-1; i >= 0; i--) q.push_back(e[i*8 +: 8]);
    return q;
  endfunction

  bit            m_armed, m_failed, m_sending, m_halt, m_pend, m_pend_fail, m_cur_fail;
  bit            m_fe, m_pe;
  int            m_idx;
  logic [IB-1:0] m_iter, m_ni;
  bq_t           m_frame, m_pframe, m_ef;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_armed = 0; m_failed = 0; m_sending = 0; m_halt = 0; m_pend = 0;
      m_pend_fail = 0; m_cur_fail = 0; m_idx = 0; m_iter = '0;
      m_frame = {}; m_pframe = {};
    end else begin
      m_fe = m_armed && !test_pass && !m_failed;
      m_pe = test_done && !m_failed && !m_fe;
      m_ni = (m_pe && m_iter != '1) ? m_iter + 1'b1 : m_iter;
      m_ef = mk(m_fe, ps, m_ni, rd, ex);
      if (m_sending) begin
        if (tx_ready) begin
          m_idx++;
          if (m_idx == FL) begin m_sending = 0; m_halt = m_cur_fail; end
        end
        if ((m_fe || m_pe) && (m_fe || !m_pend_fail)) begin
          m_pend = 1; m_pframe = m_ef; m_pend_fail = m_fe;
        end
      end else if (!m_halt) begin
        if (m_fe || m_pe) begin
          m_frame = m_ef; m_cur_fail = m_fe; m_sending = 1; m_idx = 0; m_pend = 0;
        end else if (m_pend) begin
          m_frame = m_pframe; m_cur_fail = m_pend_fail; m_sending = 1; m_idx = 0; m_pend = 0;
        end
      end
      if (test_pass) m_armed = 1;
      if (m_fe) m_failed = 1;
      m_iter = m_ni;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("tx_valid", tx_valid, m_sending);
      if (m_sending) chk("tx_data", tx_data, m_frame[m_idx]);
      chk("iter_count", iter_count, m_iter);
      chk("failed", failed, m_failed);
      chk("busy", busy, m_sending || m_halt || m_pend);
    end
  end

  // Captured byte stream (bytes accepted at the next rising edge).
  bq_t cap;
  always @(negedge clk) if (reset_n && tx_valid && tx_ready) cap.push_back(tx_data);

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic pulse(); test_done = 1; tick(); test_done = 0; endtask

  task automatic do_reset();
    reset_n = 0; test_done = 0; test_pass = 0; tx_ready = 0; ps = 0; rd = 0; ex = 0;
    tick(); tick();
    reset_n = 1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_failed", failed, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic chk_frame(string nm, logic [7:0] e[8], int off);
    chk({nm, "_len"}, cap.size(), off + 8);
    if (cap.size() >= off + 8)
      for (int i = 0; i < 8; i++) chk(nm, cap[off+i], e[i]);
  endtask

  logic [7:0] f1[8] = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h12, 8'h34};
  logic [7:0] f3[8] = '{8'hA5, 8'h83, 8'h00, 8'h05, 8'hBE, 8'hEF, 8'hBE, 8'hEE};

  initial begin
    // 1: single pass frame
    do_reset();
    test_pass = 1; rd = 16'h1234; ex = 16'h1234; tx_ready = 1;
    tick(); tick(); cap.delete();
    pulse(); repeat (12) tick();
    chk_frame("t1_frame", f1, 0);
    chk("t1_iter", iter_count, 1);

    // 4: sink stalls at frame start
    tx_ready = 0; pulse();
    for (int i = 0; i < 5 && !tx_valid; i++) tick();
    repeat (10) begin
      tick();
      chk("t4_hold_valid", tx_valid, 1);
      chk("t4_hold_data", tx_data, 8'hA5);
    end
    tx_ready = 1; repeat (12) tick();
    chk("t4_iter", iter_count, 2);

    // 5: three passes during one frame coalesce
    cap.delete();
    pulse(); tick(); tick(); pulse(); tick(); pulse(); tick(); pulse();
    repeat (25) tick();
    chk("t5_len", cap.size(), 16);
    if (cap.size() >= 16) begin
      chk("t5_first_iter", cap[3], 8'h03);
      chk("t5_follow_iter", cap[11], 8'h06);
      chk("t5_follow_hdr", cap[8], 8'hA5);
    end
    chk("t5_iter", iter_count, 6);

    // 2: power-up test_pass=0 is masked until armed
    do_reset();
    tx_ready = 1; cap.delete();
    repeat (100) tick();
    test_pass = 1; repeat (5) tick();
    chk("t2_failed", failed, 0);
    chk("t2_frames", cap.size(), 0);
    chk("t2_busy", busy, 0);

    // 3: failure snapshot then halt
    repeat (5) begin pulse(); repeat (12) tick(); end
    cap.delete();
    rd = 16'hBEEF; ex = 16'hBEEE; ps = 3'd3; test_pass = 0;
    repeat (15) tick();
    chk_frame("t3_frame", f3, 0);
    pulse(); repeat (12) tick();
    chk("t3_iter_frozen", iter_count, 5);
    chk("t3_no_more", cap.size(), 8);
    chk("t3_failed", failed, 1);
    chk("t3_busy_halt", busy, 1);

    // 6: async reset mid-frame
    do_reset();
    test_pass = 1; tx_ready = 1; rd = 16'h1234; ex = 16'h1234; ps = 0;
    tick(); cap.delete();
    pulse();
    for (int i = 0; i < 20 && cap.size() < 3; i++) tick();
    chk("t6_reached_byte3", cap.size() >= 3, 1);
    reset_n = 0; #1;
    chk("t6_valid_drop", tx_valid, 0);
    chk("t6_iter", iter_count, 0);
    chk("t6_busy", busy, 0);
    tick(); tick(); reset_n = 1; tick();
    cap.delete(); pulse(); repeat (12) tick();
    chk_frame("t6_frame", f1, 0);

    // randomized traffic
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        test_pass = (c < 10) ? 1'b0 : ($urandom_range(0, 149) != 0);
        test_done = ($urandom_range(0, 4) == 0);
        tx_ready  = ($urandom_range(0, 3) != 0);
        ps = 3'($urandom); rd = DB'($urandom); ex = DB'($urandom);
        tick();
      end
      test_done = 0; tx_ready = 1; repeat (20) tick();
    end

    // saturation of the pass counter
    do_reset();
    test_pass = 1; tx_ready = 1; test_done = 1;
    repeat (65540) tick();
    test_done = 0;
    chk("sat_iter", iter_count, 16'hFFFF);
    repeat (20) tick(); cap.delete();
    pulse(); repeat (12) tick();
    chk("sat_len", cap.size(), 8);
    if (cap.size() >= 4) begin
      chk("sat_frame_hi", cap[2], 8'hFF);
      chk("sat_frame_lo", cap[3], 8'hFF);
    end
    chk("sat_iter_hold", iter_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
